// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives the data and select lines of a 4-to-1 mux and reads
// back its output once for each select code. The bits read back come out as
// a serial stream and as a reassembled word. A self-check flag reports when
// that word does not match the word that was latched.
//
// Handshake: a request on start is taken only in an edge where the
// controller is idle (busy=0). It is not queued. ser_valid qualifies
// ser_out for exactly one cycle per sample. done is a one-cycle pulse, and
// q_out/err are valid from that pulse until the next accepted start.
module mux_scan_ctrl #(
   parameter int DWELL   = 1,     // settle cycles per select code, 1..15
   parameter bit REVERSE = 1'b0   // 0: codes 0..3, 1: codes 3..0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] d_in,
   input  logic       mux_o,
   output logic       s1,
   output logic       s0,
   output logic       d0,
   output logic       d1,
   output logic       d2,
   output logic       d3,
   output logic       busy,
   output logic       done,
   output logic [3:0] q_out,
   output logic       ser_out,
   output logic       ser_valid,
   output logic       err,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] C_RELOAD = 4'(DWELL - 1);
   localparam logic [1:0] C_FIRST  = REVERSE ? 2'd3 : 2'd0;
   localparam logic [1:0] C_LAST   = REVERSE ? 2'd0 : 2'd3;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [1:0] r_code;
   logic [3:0] r_data;
   logic [3:0] r_q;
   logic       r_busy;
   logic       r_done;
   logic       r_ser_out;
   logic       r_ser_valid;
   logic       r_err;
   logic [3:0] w_q_next;

   // Word as it will look once the current mux output is written into the slot for the current code
   always_comb begin
      w_q_next         = r_q;
      w_q_next[r_code] = mux_o;
   end

   // Scan sequencer; all outputs are registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_code      <= 2'd0;
         r_data      <= 4'd0;
         r_q         <= 4'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ser_out   <= 1'b0;
         r_ser_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_ser_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_data  <= d_in;
                  r_code  <= C_FIRST;
                  r_cnt   <= C_RELOAD;
                  r_q     <= 4'd0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_SAMPLE: begin
               r_q         <= w_q_next;
               r_ser_out   <= mux_o;
               r_ser_valid <= 1'b1;
               if (r_code == C_LAST) begin
                  // The code stops at the last code and never wraps inside a scan
                  r_err   <= (w_q_next != r_data);
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_code  <= REVERSE ? (r_code - 2'd1) : (r_code + 2'd1);
                  r_cnt   <= C_RELOAD;
                  r_state <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               // A start seen in this cycle is dropped; it is taken again in the next IDLE cycle
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign s1          = r_code[1];
   assign s0          = r_code[0];
   assign d0          = r_data[0];
   assign d1          = r_data[1];
   assign d2          = r_data[2];
   assign d3          = r_data[3];
   assign busy        = r_busy;
   assign done        = r_done;
   assign q_out       = r_q;
   assign ser_out     = r_ser_out;
   assign ser_valid   = r_ser_valid;
   assign err         = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: two controllers share one clock and one reset.
// Instance A is forward with DWELL=1. Instance B is reverse with DWELL=3.
// Each instance drives a behavioural 4-to-1 mux. That mux can be forced
// stuck-at-0 to emulate a faulty path.
module tb_mux_scan_ctrl;

   localparam int DW_A  = 1;
   localparam bit REV_A = 1'b0;
   localparam int DW_B  = 3;
   localparam bit REV_B = 1'b1;

   logic clk;
   logic rst_n;

   logic       start_a, start_b;
   logic [3:0] din_a, din_b;
   logic       stuck_a, stuck_b;
   logic       mux_o_a, mux_o_b;
   logic       s1_a, s0_a, d0_a, d1_a, d2_a, d3_a, busy_a, done_a, so_a, sv_a, err_a;
   logic       s1_b, s0_b, d0_b, d1_b, d2_b, d3_b, busy_b, done_b, so_b, sv_b, err_b;
   logic [3:0] q_a, q_b;
   logic [1:0] st_a, st_b;
   logic [3:0] dv_a, dv_b;
   logic [16:0] all_a, all_b;

   int n_assert = 0;
   int n_fail   = 0;

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // behavioural 4-to-1 mux: o = d[{s1,s0}], optionally stuck at 0
   assign dv_a    = {d3_a, d2_a, d1_a, d0_a};
   assign dv_b    = {d3_b, d2_b, d1_b, d0_b};
   assign mux_o_a = stuck_a ? 1'b0 : dv_a[{s1_a, s0_a}];
   assign mux_o_b = stuck_b ? 1'b0 : dv_b[{s1_b, s0_b}];
   assign all_a   = {s1_a, s0_a, dv_a, busy_a, done_a, q_a, so_a, sv_a, err_a, st_a};
   assign all_b   = {s1_b, s0_b, dv_b, busy_b, done_b, q_b, so_b, sv_b, err_b, st_b};

   mux_scan_ctrl #(.DWELL(DW_A), .REVERSE(REV_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .d_in(din_a), .mux_o(mux_o_a),
      .s1(s1_a), .s0(s0_a), .d0(d0_a), .d1(d1_a), .d2(d2_a), .d3(d3_a),
      .busy(busy_a), .done(done_a), .q_out(q_a), .ser_out(so_a),
      .ser_valid(sv_a), .err(err_a), .o_dbg_state(st_a)
   );

   mux_scan_ctrl #(.DWELL(DW_B), .REVERSE(REV_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .d_in(din_b), .mux_o(mux_o_b),
      .s1(s1_b), .s0(s0_b), .d0(d0_b), .d1(d1_b), .d2(d2_b), .d3(d3_b),
      .busy(busy_b), .done(done_b), .q_out(q_b), .ser_out(so_b),
      .ser_valid(sv_b), .err(err_b), .o_dbg_state(st_b)
   );

   // one comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver: request line and data word of one instance
   task automatic drive(input bit which, input logic st, input logic [3:0] dv);
      if (which) begin
         start_b = st;
         din_b   = dv;
      end else begin
         start_a = st;
         din_a   = dv;
      end
   endtask

   // One scan on one instance, checked cycle by cycle against the timeline:
   // start is accepted at edge 0. Sample k (k=1..4) is taken at edge k*(DWELL+1).
   // done follows edge 4*(DWELL+1), and busy drops one edge later.
   // disturb: start pulses at edges 3, 8 and 9 carrying a different word.
   // rst_at: edge after which reset is asserted (-1 = never).
   task automatic run_scan(input bit which, input logic [3:0] data, input bit stuck,
                           input bit disturb, input int rst_at);
      int         dw, per, last, ns, ci, cj;
      bit         rev;
      logic [1:0] code;
      logic [3:0] q_exp, final_q;
      logic       err_final;
      logic [1:0] o_sel;
      logic [3:0] o_d, o_q;
      logic       o_busy, o_done, o_sv, o_so, o_err;
      dw   = which ? DW_B : DW_A;
      rev  = which ? REV_B : REV_A;
      per  = dw + 1;
      last = 4 * per;
      if (which) stuck_b = stuck; else stuck_a = stuck;
      final_q   = stuck ? 4'd0 : data;
      err_final = (final_q != data);
      drive(which, 1'b1, data);
      for (int t = 0; t <= last + 1; t++) begin
         @(posedge clk);
         #1;
         if (t == 0) drive(which, 1'b0, 4'($urandom_range(0, 15)));
         if (disturb && (t == 2 || t == 7)) drive(which, 1'b1, ~data);
         if (disturb && t == 3) drive(which, 1'b0, 4'($urandom_range(0, 15)));
         if (disturb && t == last + 1) drive(which, 1'b0, data);
         if (t == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("async_reset_outputs", which ? all_b : all_a, 17'd0);
            repeat (2) begin
               @(posedge clk);
               #1;
               chk("no_done_in_reset", which ? done_b : done_a, 1'b0);
            end
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         o_sel  = which ? {s1_b, s0_b} : {s1_a, s0_a};
         o_d    = which ? dv_b : dv_a;
         o_q    = which ? q_b : q_a;
         o_busy = which ? busy_b : busy_a;
         o_done = which ? done_b : done_a;
         o_sv   = which ? sv_b : sv_a;
         o_so   = which ? so_b : so_a;
         o_err  = which ? err_b : err_a;
         // reference: sample j uses code j (or 3-j in reverse order)
         ns = (t / per > 4) ? 4 : t / per;
         ci = (t / per > 3) ? 3 : t / per;
         code = rev ? 2'(3 - ci) : 2'(ci);
         q_exp = 4'd0;
         for (int j = 0; j < ns; j++) begin
            cj = rev ? 3 - j : j;
            q_exp[cj] = final_q[cj];
         end
         chk("select_code", o_sel, code);
         chk("data_lines", o_d, data);
         chk("busy", o_busy, (t <= last));
         chk("done", o_done, (t == last));
         chk("ser_valid", o_sv, (t > 0 && t % per == 0 && t <= last));
         chk("q_out", o_q, q_exp);
         chk("err", o_err, (t >= last) ? err_final : 1'b0);
         if (t > 0 && t % per == 0 && t <= last) begin
            cj = rev ? 3 - (t / per - 1) : (t / per - 1);
            chk("ser_out", o_so, final_q[cj]);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      din_a   = 4'd0;
      din_b   = 4'd0;
      stuck_a = 1'b0;
      stuck_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_values_a", all_a, 17'd0);
      chk("reset_values_b", all_b, 17'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // forward loopback, DWELL=1
      run_scan(1'b0, 4'b1010, 1'b0, 1'b0, -1);
      // reverse order, DWELL=3
      run_scan(1'b1, 4'b0011, 1'b0, 1'b0, -1);
      // stuck-at-0 mux output: err rises with done and holds while idle
      run_scan(1'b0, 4'b1010, 1'b1, 1'b0, -1);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("err_held", err_a, 1'b1);
         chk("q_held", q_a, 4'b0000);
         chk("data_held", dv_a, 4'b1010);
      end
      // starts during busy and in the DONE cycle are dropped; next start latches the new word
      run_scan(1'b0, 4'b0101, 1'b0, 1'b1, -1);
      run_scan(1'b0, 4'b1010, 1'b0, 1'b0, -1);
      // reset in the middle of a scan, then a clean scan
      run_scan(1'b0, 4'b1100, 1'b0, 1'b0, 5);
      run_scan(1'b0, 4'b0110, 1'b0, 1'b0, -1);
      // all 16 words back-to-back
      for (int v = 0; v < 16; v++) run_scan(1'b0, 4'(v), 1'b0, 1'b0, -1);
      // random scans on either instance, occasionally with a stuck mux
      repeat (8) begin
         run_scan(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), 1'b0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
